// File: rtl/commit_controller_pkg.sv
// Shared types for the commit stage: buffer entry layout, entry/unit/op enums and commit FSM states.
// Sizes here are the single source of truth for the reservation buffer and its tag width.
package commit_controller_pkg;

  localparam int BUF_SIZE     = 8;
  localparam int BUF_SIZE_LOG = 3;
  localparam int TAG_W        = BUF_SIZE_LOG + 1;
  localparam int COMMIT_WIDTH = 2;

  typedef enum logic [1:0] {
    S_NOT_USED,
    S_WAITING,
    S_EXECUTING,
    S_EXECUTED
  } e_state_t;

  typedef enum logic [1:0] {
    ALU,
    BRANCH,
    LOAD,
    STORE
  } unit_t;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_LB,
    OP_LH,
    OP_LW,
    OP_SB,
    OP_SH,
    OP_SW,
    OP_BEQ,
    OP_BNE
  } op_t;

  typedef enum logic [1:0] {
    C_RUN,
    C_STORE,
    C_FLUSH
  } commit_state_t;

  typedef struct packed {
    e_state_t          e_state;
    logic [TAG_W-1:0]  tag;
    unit_t             unit;
    op_t               op;
    logic [4:0]        dest;
    logic [31:0]       vk;
    logic [31:0]       result;
    logic [31:0]       pc;
  } entry_t;

  // A branch's result holds its resolved next PC; anything but fall-through means fetch went the wrong way.
  function automatic logic is_mispredict(input unit_t unit, input logic [31:0] result,
                                         input logic [31:0] pc);
    return (unit == BRANCH) && (result != pc + 32'd4);
  endfunction

endpackage

// File: rtl/commit_controller_oldest_pair_finder.sv
// Combinational search for the two oldest used buffer entries.
// Older means a larger tag; index[0] is the oldest, index[1] the next oldest.
module oldest_pair_finder
  import commit_controller_pkg::*;
(
  input  logic [BUF_SIZE-1:0]     used,
  input  logic [TAG_W-1:0]        tags  [BUF_SIZE],
  output logic [COMMIT_WIDTH-1:0] valid,
  output logic [BUF_SIZE_LOG-1:0] index [COMMIT_WIDTH]
);

  logic                    best_valid;
  logic                    second_valid;
  logic [BUF_SIZE_LOG-1:0] best_index;
  logic [BUF_SIZE_LOG-1:0] second_index;
  logic [TAG_W-1:0]        best_tag;
  logic [TAG_W-1:0]        second_tag;

  // A new maximum demotes the previous maximum to second place.
  always_comb begin
    best_valid   = 1'b0;
    second_valid = 1'b0;
    best_index   = '0;
    second_index = '0;
    best_tag     = '0;
    second_tag   = '0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (used[i]) begin
        if (!best_valid || (tags[i] > best_tag)) begin
          second_valid = best_valid;
          second_index = best_index;
          second_tag   = best_tag;
          best_valid   = 1'b1;
          best_index   = BUF_SIZE_LOG'(i);
          best_tag     = tags[i];
        end else if (!second_valid || (tags[i] > second_tag)) begin
          second_valid = 1'b1;
          second_index = BUF_SIZE_LOG'(i);
          second_tag   = tags[i];
        end
      end
    end
  end

  assign valid    = {second_valid, best_valid};
  assign index[0] = best_index;
  assign index[1] = second_index;

endmodule

// File: rtl/commit_controller.sv
// In-order commit: retires up to two entries per cycle, serialises stores over a req/ack port,
// and raises a one-cycle flush with redirect PC on a mispredicted branch. Define COMMIT_PERF_EN for perf counters.
module commit_controller
  import commit_controller_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  entry_t                  entries_all [BUF_SIZE],
  output logic [COMMIT_WIDTH-1:0] free_valid,
  output logic [BUF_SIZE_LOG-1:0] free_index  [COMMIT_WIDTH],
  output logic [COMMIT_WIDTH-1:0] reg_we,
  output logic [4:0]              reg_waddr   [COMMIT_WIDTH],
  output logic [31:0]             reg_wdata   [COMMIT_WIDTH],
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  output op_t                     mem_op,
  input  logic                    mem_ack,
  output logic                    flush,
  output logic [31:0]             redirect_pc,
  output logic [31:0]             retired_count,
  output logic [15:0]             flush_count
);

  commit_state_t           state;
  commit_state_t           next_state;
  logic [BUF_SIZE-1:0]     used;
  logic [TAG_W-1:0]        tags [BUF_SIZE];
  logic [COMMIT_WIDTH-1:0] oldest_valid;
  logic [BUF_SIZE_LOG-1:0] oldest_index [COMMIT_WIDTH];
  logic [BUF_SIZE_LOG-1:0] store_index;

  logic slot0_exec;
  logic slot0_store;
  logic slot0_mispred;
  logic slot1_ok;
  logic retire0;
  logic retire1;
  logic store_start;
  logic flush_start;

  for (genvar g = 0; g < BUF_SIZE; g++) begin : g_tags
    assign used[g] = (entries_all[g].e_state != S_NOT_USED);
    assign tags[g] = entries_all[g].tag;
  end

  oldest_pair_finder u_finder (
    .used  (used),
    .tags  (tags),
    .valid (oldest_valid),
    .index (oldest_index)
  );

  // Slot 1 may only ride along behind a plain, correctly predicted slot-0 retirement.
  assign slot0_exec    = oldest_valid[0] && (entries_all[oldest_index[0]].e_state == S_EXECUTED);
  assign slot0_store   = (entries_all[oldest_index[0]].unit == STORE);
  assign slot0_mispred = is_mispredict(entries_all[oldest_index[0]].unit,
                                       entries_all[oldest_index[0]].result,
                                       entries_all[oldest_index[0]].pc);
  assign slot1_ok      = oldest_valid[1]
                         && (entries_all[oldest_index[1]].e_state == S_EXECUTED)
                         && (entries_all[oldest_index[1]].unit != STORE);
  assign retire0       = (state == C_RUN) && slot0_exec && !slot0_store;
  assign retire1       = retire0 && !slot0_mispred && slot1_ok;
  assign store_start   = (state == C_RUN) && slot0_exec && slot0_store;
  assign flush_start   = retire0 && slot0_mispred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= C_RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      C_RUN: begin
        if (flush_start) begin
          next_state = C_FLUSH;
        end else if (store_start) begin
          next_state = C_STORE;
        end
      end
      C_STORE: begin
        if (mem_ack) begin
          next_state = C_RUN;
        end
      end
      C_FLUSH: begin
        next_state = C_RUN;
      end
      default: begin
        next_state = C_RUN;
      end
    endcase
  end

  // Store completion reuses port 0; the store entry is still oldest, but its index is latched to be safe.
  always_comb begin
    free_valid[0] = retire0 || ((state == C_STORE) && mem_ack);
    free_valid[1] = retire1;
    free_index[0] = (state == C_STORE) ? store_index : oldest_index[0];
    free_index[1] = oldest_index[1];
    reg_we[0]     = retire0 && (entries_all[oldest_index[0]].dest != 5'd0);
    reg_we[1]     = retire1 && (entries_all[oldest_index[1]].dest != 5'd0);
    reg_waddr[0]  = entries_all[oldest_index[0]].dest;
    reg_waddr[1]  = entries_all[oldest_index[1]].dest;
    reg_wdata[0]  = entries_all[oldest_index[0]].result;
    reg_wdata[1]  = entries_all[oldest_index[1]].result;
  end

  assign mem_req = (state == C_STORE);
  assign flush   = (state == C_FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_op      <= OP_ADD;
      store_index <= '0;
      redirect_pc <= '0;
    end else begin
      if (store_start) begin
        mem_addr    <= entries_all[oldest_index[0]].result;
        mem_wdata   <= entries_all[oldest_index[0]].vk;
        mem_op      <= entries_all[oldest_index[0]].op;
        store_index <= oldest_index[0];
      end
      if (flush_start) begin
        redirect_pc <= entries_all[oldest_index[0]].result;
      end
    end
  end

`ifdef COMMIT_PERF_EN
  // Retirements wrap naturally; the flush counter pins at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count <= '0;
      flush_count   <= '0;
    end else begin
      retired_count <= retired_count + 32'(free_valid[0]) + 32'(free_valid[1]);
      if (flush && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`else
  assign retired_count = '0;
  assign flush_count   = '0;
`endif

endmodule

// File: tb/tb_commit_controller.sv
// Directed bench for commit_controller: dual retire, stall, store handshake, mispredict flush, reset mid-store.
// Expected counter values follow COMMIT_PERF_EN when the bench is built with it.
module tb_commit_controller;
  import commit_controller_pkg::*;

  logic                    clk;
  logic                    rst_n;
  entry_t                  entries_all [BUF_SIZE];
  logic [COMMIT_WIDTH-1:0] free_valid;
  logic [BUF_SIZE_LOG-1:0] free_index  [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] reg_we;
  logic [4:0]              reg_waddr   [COMMIT_WIDTH];
  logic [31:0]             reg_wdata   [COMMIT_WIDTH];
  logic                    mem_req;
  logic [31:0]             mem_addr;
  logic [31:0]             mem_wdata;
  op_t                     mem_op;
  logic                    mem_ack;
  logic                    flush;
  logic [31:0]             redirect_pc;
  logic [31:0]             retired_count;
  logic [15:0]             flush_count;

  int checks;
  int errors;
  logic [31:0] exp_retired;
  logic [31:0] exp_flushes;

  commit_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .entries_all   (entries_all),
    .free_valid    (free_valid),
    .free_index    (free_index),
    .reg_we        (reg_we),
    .reg_waddr     (reg_waddr),
    .reg_wdata     (reg_wdata),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_op        (mem_op),
    .mem_ack       (mem_ack),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .retired_count (retired_count),
    .flush_count   (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [TAG_W-1:0] tag, input e_state_t st,
                               input unit_t unit, input op_t op, input logic [4:0] dest,
                               input logic [31:0] result, input logic [31:0] vk, input logic [31:0] pc);
    entries_all[idx].e_state = st;
    entries_all[idx].tag     = tag;
    entries_all[idx].unit    = unit;
    entries_all[idx].op      = op;
    entries_all[idx].dest    = dest;
    entries_all[idx].result  = result;
    entries_all[idx].vk      = vk;
    entries_all[idx].pc      = pc;
  endtask

  task automatic clearEntry(input int idx);
    applyStimulus(idx, '0, S_NOT_USED, ALU, OP_ADD, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    for (int i = 0; i < BUF_SIZE; i++) clearEntry(i);

    // Reset values
    @(negedge clk); #1;
    checkOutput("rst_free_valid", 32'(free_valid), 32'h0);
    checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
    checkOutput("rst_flush", 32'(flush), 32'h0);
    checkOutput("rst_redirect", redirect_pc, 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_retired", retired_count, 32'h0);
    checkOutput("rst_flushcnt", 32'(flush_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two executed ALU entries retire together; a younger waiting entry is ignored
    @(negedge clk);
    applyStimulus(2, 4'd15, S_EXECUTED, ALU, OP_ADD, 5'd5, 32'h11, 32'h0, 32'h0);
    applyStimulus(5, 4'd14, S_EXECUTED, ALU, OP_ADD, 5'd6, 32'h22, 32'h0, 32'h4);
    applyStimulus(0, 4'd3,  S_WAITING,  ALU, OP_ADD, 5'd9, 32'h55, 32'h0, 32'h8);
    #1;
    checkOutput("dual_free_valid", 32'(free_valid), 32'h3);
    checkOutput("dual_idx0", 32'(free_index[0]), 32'd2);
    checkOutput("dual_idx1", 32'(free_index[1]), 32'd5);
    checkOutput("dual_reg_we", 32'(reg_we), 32'h3);
    checkOutput("dual_waddr0", 32'(reg_waddr[0]), 32'd5);
    checkOutput("dual_waddr1", 32'(reg_waddr[1]), 32'd6);
    checkOutput("dual_wdata0", reg_wdata[0], 32'h11);
    checkOutput("dual_wdata1", reg_wdata[1], 32'h22);

    // Oldest not executed blocks the executed younger entry
    @(negedge clk);
    clearEntry(2);
    clearEntry(5);
    applyStimulus(1, 4'd13, S_WAITING,  ALU, OP_ADD, 5'd7, 32'h0,  32'h0, 32'h0);
    applyStimulus(4, 4'd12, S_EXECUTED, ALU, OP_ADD, 5'd0, 32'h33, 32'h0, 32'h0);
    #1;
    checkOutput("stall_free_valid", 32'(free_valid), 32'h0);
    checkOutput("stall_reg_we", 32'(reg_we), 32'h0);
    @(negedge clk); #1;
    checkOutput("stall2_free_valid", 32'(free_valid), 32'h0);
    @(negedge clk);
    applyStimulus(1, 4'd13, S_EXECUTED, ALU, OP_ADD, 5'd7, 32'h44, 32'h0, 32'h0);
    #1;
    checkOutput("unstall_free_valid", 32'(free_valid), 32'h3);
    checkOutput("unstall_idx0", 32'(free_index[0]), 32'd1);
    checkOutput("unstall_idx1", 32'(free_index[1]), 32'd4);
    checkOutput("unstall_reg_we_dest0", 32'(reg_we), 32'h1);
    checkOutput("unstall_wdata0", reg_wdata[0], 32'h44);
    checkOutput("unstall_wdata1", reg_wdata[1], 32'h33);

    // Store with ack delayed three cycles; younger executed entry waits behind it
    @(negedge clk);
    clearEntry(1);
    clearEntry(4);
    applyStimulus(6, 4'd11, S_EXECUTED, STORE, OP_SW, 5'd0, 32'h100, 32'hAB, 32'h0);
    applyStimulus(0, 4'd3,  S_EXECUTED, ALU,   OP_ADD, 5'd9, 32'h55, 32'h0, 32'h8);
    #1;
    checkOutput("st_first_free", 32'(free_valid), 32'h0);
    checkOutput("st_first_reg_we", 32'(reg_we), 32'h0);
    checkOutput("st_first_req", 32'(mem_req), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checkOutput("st_wait_req", 32'(mem_req), 32'h1);
      checkOutput("st_wait_addr", mem_addr, 32'h100);
      checkOutput("st_wait_wdata", mem_wdata, 32'hAB);
      checkOutput("st_wait_op", 32'(mem_op), 32'(OP_SW));
      checkOutput("st_wait_free", 32'(free_valid), 32'h0);
    end
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    checkOutput("st_ack_free", 32'(free_valid), 32'h1);
    checkOutput("st_ack_idx", 32'(free_index[0]), 32'd6);
    checkOutput("st_ack_reg_we", 32'(reg_we), 32'h0);
    @(negedge clk);
    mem_ack = 1'b0;
    clearEntry(6);
    #1;
    checkOutput("st_done_req", 32'(mem_req), 32'h0);
    checkOutput("st_next_free", 32'(free_valid), 32'h1);
    checkOutput("st_next_idx", 32'(free_index[0]), 32'd0);
    checkOutput("st_next_waddr", 32'(reg_waddr[0]), 32'd9);
    checkOutput("st_next_wdata", reg_wdata[0], 32'h55);

    // Mispredicted branch retires alone, then one flush cycle
    @(negedge clk);
    clearEntry(0);
    applyStimulus(3, 4'd10, S_EXECUTED, BRANCH, OP_BEQ, 5'd0,  32'h80, 32'h0, 32'h40);
    applyStimulus(7, 4'd9,  S_EXECUTED, ALU,    OP_ADD, 5'd10, 32'h77, 32'h0, 32'h44);
    #1;
    checkOutput("br_free", 32'(free_valid), 32'h1);
    checkOutput("br_idx", 32'(free_index[0]), 32'd3);
    checkOutput("br_reg_we", 32'(reg_we), 32'h0);
    checkOutput("br_no_flush_yet", 32'(flush), 32'h0);
    @(negedge clk);
    clearEntry(3);
    #1;
    checkOutput("fl_flush", 32'(flush), 32'h1);
    checkOutput("fl_redirect", redirect_pc, 32'h80);
    checkOutput("fl_free", 32'(free_valid), 32'h0);

    // Correctly predicted branch lets the younger entry retire alongside it
    @(negedge clk);
    clearEntry(7);
    applyStimulus(2, 4'd8, S_EXECUTED, BRANCH, OP_BNE, 5'd1, 32'h44, 32'h0, 32'h40);
    applyStimulus(5, 4'd7, S_EXECUTED, ALU,    OP_ADD, 5'd2, 32'h66, 32'h0, 32'h44);
    #1;
    checkOutput("flush_ended", 32'(flush), 32'h0);
    checkOutput("okbr_free", 32'(free_valid), 32'h3);
    checkOutput("okbr_reg_we", 32'(reg_we), 32'h3);
    @(negedge clk);
    clearEntry(2);
    clearEntry(5);
    #1;
    checkOutput("okbr_no_flush", 32'(flush), 32'h0);

    // Retired: 2 + 2 + store 1 + 1 + branch 1 + 2 = 9; one flush
`ifdef COMMIT_PERF_EN
    exp_retired = 32'd9;
    exp_flushes = 32'd1;
`else
    exp_retired = 32'd0;
    exp_flushes = 32'd0;
`endif
    checkOutput("perf_retired", retired_count, exp_retired);
    checkOutput("perf_flushes", 32'(flush_count), exp_flushes);

    // Reset in the middle of a store handshake
    applyStimulus(1, 4'd6, S_EXECUTED, STORE, OP_SW, 5'd0, 32'h200, 32'hCD, 32'h0);
    @(negedge clk); #1;
    checkOutput("rs_req_before", 32'(mem_req), 32'h1);
    checkOutput("rs_addr_before", mem_addr, 32'h200);
    rst_n = 1'b0;
    #1;
    checkOutput("rs_req_async", 32'(mem_req), 32'h0);
    checkOutput("rs_addr_async", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    clearEntry(1);
    applyStimulus(4, 4'd5, S_EXECUTED, ALU, OP_ADD, 5'd3, 32'h99, 32'h0, 32'h0);
    #1;
    checkOutput("rs_run_free", 32'(free_valid), 32'h1);
    checkOutput("rs_run_idx", 32'(free_index[0]), 32'd4);
    checkOutput("rs_retired", retired_count, 32'h0);
    checkOutput("rs_flushcnt", 32'(flush_count), 32'h0);
    @(negedge clk);
    clearEntry(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
